// File: rtl/bcd_counter_chain_if.sv
// Control, load and display signals of the BCD counter chain, with
// master (driver) and slave (counter) views.
interface bcd_counter_chain_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    clr;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic                    en;
  logic                    up_dn;
  logic [4*NUM_DIGITS-1:0] display;
  logic                    cout;
  logic                    wrap;

  modport master (
    output clr, load, load_val, en, up_dn,
    input  display, cout, wrap
  );

  modport slave (
    input  clr, load, load_val, en, up_dn,
    output display, cout, wrap
  );
endinterface

// File: rtl/bcd_counter_chain.sv
// Multi-digit synchronous BCD up/down counter with load, clear and cascade cout.
// Optional macro BCD_COUNTER_SATURATE_EN: saturate at all 9s / all 0s instead of wrapping.
module bcd_counter_chain #(
  parameter int                      NUM_DIGITS = 4,
  parameter logic [4*NUM_DIGITS-1:0] INIT_VAL   = '0
) (
  input  logic                clk,
  input  logic                rst,
  bcd_counter_chain_if.slave  bus
);
  localparam int W = 4 * NUM_DIGITS;

  logic [W-1:0] display_q;
  logic [W-1:0] display_d;
  logic         wrap_q;
  logic         wrap_d;
  logic [W-1:0] stepped_s;
  logic         terminal_s;
  logic [W-1:0] load_mod_s;
  logic         count_s;

  function automatic logic [3:0] mod10(input logic [3:0] nib);
    if (nib > 4'd9) begin
      return nib - 4'd10;
    end else begin
      return nib;
    end
  endfunction

  // Returns {all digits at terminal value, value after one step}.
  // The carry/borrow propagates through every digit within one evaluation.
  function automatic logic [W:0] step_chain(input logic [W-1:0] val, input logic up);
    logic         carry;
    logic [3:0]   dig;
    logic [W-1:0] nxt;
    carry = 1'b1;
    nxt   = val;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig = val[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (dig == 4'd9) begin
            nxt[4*i +: 4] = 4'd0;
          end else begin
            nxt[4*i +: 4] = dig + 4'd1;
            carry         = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            nxt[4*i +: 4] = 4'd9;
          end else begin
            nxt[4*i +: 4] = dig - 4'd1;
            carry         = 1'b0;
          end
        end
      end else begin
        nxt[4*i +: 4] = dig;
      end
    end
    return {carry, nxt};
  endfunction

  // Per-digit mod-10 fold of the load value.
  always_comb begin
    load_mod_s = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_mod_s[4*i +: 4] = mod10(bus.load_val[4*i +: 4]);
    end
  end

  // Next-state selection with priority clr > load > en.
  always_comb begin
    {terminal_s, stepped_s} = step_chain(display_q, bus.up_dn);
    count_s   = bus.en & ~bus.clr & ~bus.load;
    display_d = display_q;
    wrap_d    = 1'b0;
    if (bus.clr) begin
      display_d = '0;
    end else if (bus.load) begin
      display_d = load_mod_s;
    end else if (bus.en) begin
      wrap_d = terminal_s;
`ifdef BCD_COUNTER_SATURATE_EN
      if (terminal_s) begin
        display_d = display_q;
      end else begin
        display_d = stepped_s;
      end
`else
      display_d = stepped_s;
`endif
    end else begin
      display_d = display_q;
    end
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display_q <= INIT_VAL;
      wrap_q    <= 1'b0;
    end else begin
      display_q <= display_d;
      wrap_q    <= wrap_d;
    end
  end

  assign bus.display = display_q;
  assign bus.wrap    = wrap_q;
  assign bus.cout    = count_s & terminal_s;
endmodule

// File: tb/tb_bcd_counter_chain.sv
// Self-checking bench for bcd_counter_chain: directed vector table, corner
// sequences and randomized cycles against an integer-arithmetic model.
module tb_bcd_counter_chain;
  localparam int ND  = 4;
  localparam int MAX = 9999;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_counter_chain_if #(.NUM_DIGITS(ND)) bus ();

  bcd_counter_chain #(.NUM_DIGITS(ND), .INIT_VAL(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int m_val;
  bit m_wrap;

  typedef struct {
    bit          c;
    bit          l;
    logic [15:0] lv;
    bit          e;
    bit          u;
    logic [15:0] exp_disp;
    bit          exp_wrap;
    bit          exp_cout;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = 16'h0000;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int load2int(input logic [15:0] lv);
    int v;
    v = 0;
    for (int i = ND - 1; i >= 0; i--) begin
      v = v * 10 + (int'(lv[4*i +: 4]) % 10);
    end
    return v;
  endfunction

  // One clock cycle: drive at negedge, check cout before the edge and
  // display/wrap after it against the model.
  task automatic cycle(input bit c, input bit l, input logic [15:0] lv,
                       input bit e, input bit u, output bit cout_seen);
    bit term;
    int nv;
    bit nw;
    @(negedge clk);
    bus.clr = c; bus.load = l; bus.load_val = lv; bus.en = e; bus.up_dn = u;
    #1;
    term = u ? (m_val == MAX) : (m_val == 0);
    cout_seen = bus.cout;
    check("cout", int'(bus.cout), int'(e && !c && !l && term));
    nv = m_val;
    nw = 1'b0;
    if (c) begin
      nv = 0;
    end else if (l) begin
      nv = load2int(lv);
    end else if (e) begin
      if (term) begin
        nw = 1'b1;
`ifdef BCD_COUNTER_SATURATE_EN
        nv = m_val;
`else
        nv = u ? 0 : MAX;
`endif
      end else begin
        nv = u ? m_val + 1 : m_val - 1;
      end
    end
    @(posedge clk);
    #1;
    m_val  = nv;
    m_wrap = nw;
    check("display", int'(bus.display), int'(int2bcd(m_val)));
    check("wrap", int'(bus.wrap), int'(m_wrap));
  endtask

  initial begin
    bit co;
    rst = 1'b1;
    bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = 16'h0000;
    bus.en = 1'b0; bus.up_dn = 1'b0;
    m_val = 0; m_wrap = 1'b0;
    #1;
    check("reset_display", int'(bus.display), 0);
    check("reset_wrap", int'(bus.wrap), 0);
    @(negedge clk);
    rst = 1'b0;

    //           c     l     lv        e     u     disp      wrap  cout
    vecs[0]  = '{1'b0, 1'b1, 16'h0999, 1'b0, 1'b0, 16'h0999, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0};
`ifdef BCD_COUNTER_SATURATE_EN
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h9999, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0};
`else
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
`endif
    vecs[5]  = '{1'b0, 1'b1, 16'hFABC, 1'b0, 1'b0, 16'h5012, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 16'h4321, 1'b0, 1'b0, 16'h4321, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 16'h7777, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1233, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
`ifdef BCD_COUNTER_SATURATE_EN
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1};
`else
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b1};
`endif

    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].c, vecs[i].l, vecs[i].lv, vecs[i].e, vecs[i].u, co);
      check($sformatf("vec%0d_cout", i), int'(co), int'(vecs[i].exp_cout));
      check($sformatf("vec%0d_display", i), int'(bus.display), int'(vecs[i].exp_disp));
      check($sformatf("vec%0d_wrap", i), int'(bus.wrap), int'(vecs[i].exp_wrap));
    end

    // Wrap pulse lasts one cycle only.
    cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, co);
    check("wrap_one_cycle", int'(bus.wrap), 0);

    // Asynchronous reset mid-count.
    cycle(1'b0, 1'b1, 16'h0510, 1'b0, 1'b1, co);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, co);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, co);
    check("pre_reset_display", int'(bus.display), 16'h0512);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_reset_display", int'(bus.display), 0);
    check("async_reset_wrap", int'(bus.wrap), 0);
    m_val = 0; m_wrap = 1'b0;
    #2;
    rst = 1'b0;

    // 1000 down to 0, then terminal cout.
    cycle(1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, co);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, co);
    check("down_0999", int'(bus.display), 16'h0999);
    for (int i = 0; i < 999; i++) begin
      cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, co);
    end
    check("down_to_zero", int'(bus.display), 0);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, co);
    check("zero_cout", int'(co), 1);

    // Randomized cycles against the model.
    for (int i = 0; i < 400; i++) begin
      bit          rc, rl, re, ru;
      logic [15:0] rlv;
      rc  = ($urandom_range(0, 15) == 0);
      rl  = ($urandom_range(0, 7) == 0);
      re  = ($urandom_range(0, 3) != 0);
      ru  = 1'($urandom_range(0, 1));
      rlv = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        rlv = ($urandom_range(0, 1) != 0) ? 16'h9998 : 16'h0001;
      end
      cycle(rc, rl, rlv, re, ru, co);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bcd_counter_chain.md
Name: bcd_counter_chain

Overview:
Parametrised multi-digit synchronous BCD up/down counter. It generalises the single-digit combinational BCD decode (value mod 10 plus carry flag) into a registered cascade of NUM_DIGITS decimal digits, with digit-to-digit carry and borrow, parallel load, and a cascade carry-out. It feeds the seven-segment display path directly, one 4-bit BCD nibble per digit, and can be chained to further instances through cout.

Parameters:
NUM_DIGITS, 4, number of BCD digits in the chain (1..8); the display width is 4*NUM_DIGITS.
INIT_VAL, 0, reset value of display; each nibble must be 0..9.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous reset, active-high.
clr  input  1  synchronous clear to all zeros.
load  input  1  synchronous parallel load of load_val.
load_val  input  4*NUM_DIGITS  value to load; nibble 0 is the least significant digit.
en  input  1  count enable; one step per enabled cycle.
up_dn  input  1  direction: 1 counts up, 0 counts down.
display  output  4*NUM_DIGITS  registered BCD count; nibble i is decimal digit i.
cout  output  1  combinational cascade carry/borrow.
wrap  output  1  registered one-cycle pulse after a full-chain wrap.

Behaviour:
- Reset: rst high asynchronously forces display=INIT_VAL and wrap=0. cout then follows its combinational equation. Reset mid-count discards the count with no partial update.
- Priority on each rising clk edge: clr > load > en. When none is active, display holds.
- clr: display goes to all zeros and wrap=0, regardless of en, load or up_dn.
- load: each nibble d of load_val is stored as d mod 10, so nibbles 10..15 become 0..5. wrap=0. No count occurs in a load cycle.
- Count up (en=1, up_dn=1): digit 0 increments by one. When digit i goes 9->0, digit i+1 increments in the same edge. All digits update in one cycle; there is no ripple latency.
- Count down (en=1, up_dn=0): digit 0 decrements by one. When digit i goes 0->9, digit i+1 decrements in the same edge.
- Full-chain wrap: counting up from all 9s gives all 0s; counting down from all 0s gives all 9s. wrap=1 on the following cycle only, then returns to 0.
- cout = en & ~clr & ~load & (up_dn ? display==all 9s : display==all 0s). It is driven combinationally so a downstream instance can use it as its en in the same cycle.
- A single-cycle en produces exactly one step. A held en steps every cycle.
- Latency: display reflects a clr/load/count on the edge that samples it, i.e. one cycle.
- Every display nibble is always 0..9. Non-BCD states are unreachable, including after load.
- up_dn can change on any cycle; the direction sampled on the same edge applies.

Optional Feature:
BCD_COUNTER_SATURATE_EN. Defined: the counter saturates instead of wrapping. Counting up at all 9s holds all 9s; counting down at all 0s holds all 0s. wrap pulses on each enabled cycle that was blocked by saturation, and cout still asserts at the terminal value. Undefined: wrap-around behaviour as described above.

Test Plan:
- NUM_DIGITS=4, rst pulse mid-count at display=0x0512 -> display=0x0000 immediately without a clock edge; wrap=0.
- load_val=0x0999, then en=1, up_dn=1 for one cycle -> display=0x1000; cout=0; wrap=0.
- load_val=0x9999, en=1, up_dn=1 -> cout=1 before the edge; after the edge display=0x0000; wrap=1 for exactly one cycle. With BCD_COUNTER_SATURATE_EN: display=0x9999 and wrap=1.
- load_val=0x1000, en=1, up_dn=0 -> display=0x0999. Continue 999 more down steps -> display=0x0000 with cout=1.
- load_val=0xFABC -> display=0x5012 (each nibble mod 10).
- clr=1, load=1, en=1 in the same cycle from 0x4321 -> display=0x0000. load=1, en=1 together -> loaded value with no increment.
